input_conditioner: RTL and testbench

Conditions raw asynchronous board inputs (switches, push-buttons) before they reach the memory-mapped input device register. Each channel is synchronized into `clk` and debounced. The clean word drives the input device's `data_in`. A change pulse and a sticky change flag let the CPU side detect new input without polling every word.

---
 rtl/io_pkg.sv | 22 ++
 rtl/debounce_bit.sv | 62 ++++++
 rtl/input_conditioner.sv | 64 ++++++
 tb/tb_input_conditioner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_pkg : widths and helpers shared by the input/output device slice
// Revision: 1.0
// ----------------------------------------------------------------------------
package io_pkg;

  localparam int IO_WIDTH            = 32;
  localparam int IO_DEBOUNCE_DEFAULT = 16;

  // Ceiling log2, used for elaboration-time width derivation.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_bit : one channel, two-flop synchronizer plus consecutive-cycle debouncer
// Revision: 1.0
// ----------------------------------------------------------------------------
module debounce_bit
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic stable,
  output logic upd
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_upd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw_in;
      r_s2 <= r_s1;
    end
  end

  assign w_diff = r_s2 ^ r_stable;
  assign w_upd  = w_diff && (r_cnt == c_CNT_LAST);

  // Any return to the accepted level restarts the run; acceptance also restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      if (!w_diff || w_upd) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_upd) begin
        r_stable <= r_s2;
      end
    end
  end

  assign stable = r_stable;
  assign upd    = w_upd;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// input_conditioner : synchronizes and debounces raw board inputs, flags changes
// Revision: 1.0
// ----------------------------------------------------------------------------
module input_conditioner
  import io_pkg::*;
#(
  parameter int WIDTH           = IO_WIDTH,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clear_chg,
  output logic [WIDTH-1:0] data_out,
  output logic             chg_pulse,
  output logic             chg_flag
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_upd;
  logic             w_any_upd;
  logic             r_chg_pulse;
  logic             r_chg_flag;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw_in (raw_in[gi]),
      .stable (w_stable[gi]),
      .upd    (w_upd[gi])
    );
  end

  assign w_any_upd = |w_upd;

  // A new update takes priority over a coincident acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chg_pulse <= 1'b0;
      r_chg_flag  <= 1'b0;
    end else begin
      r_chg_pulse <= w_any_upd;
      if (w_any_upd) begin
        r_chg_flag <= 1'b1;
      end else if (clear_chg) begin
        r_chg_flag <= 1'b0;
      end
    end
  end

  assign data_out  = w_stable;
  assign chg_pulse = r_chg_pulse;
  assign chg_flag  = r_chg_flag;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_input_conditioner : directed and randomized checks against a history-window model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw_in;
  logic         clear_chg;
  logic [W-1:0] data_out;
  logic         chg_pulse;
  logic         chg_flag;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .clear_chg (clear_chg),
    .data_out  (data_out),
    .chg_pulse (chg_pulse),
    .chg_flag  (chg_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the synchronized level is raw_in delayed by two edges; a bit is
  // accepted when the last N synchronized samples all differ from it.
  logic [W-1:0] m_d0 = '0;
  logic [W-1:0] m_d1 = '0;
  logic [W-1:0] win[$];
  logic [W-1:0] m_data = '0;
  logic         m_pulse = 1'b0;
  logic         m_flag = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_d0 = '0; m_d1 = '0; win.delete();
      m_data = '0; m_pulse = 1'b0; m_flag = 1'b0;
    end else begin
      logic [W-1:0] samp;
      logic [W-1:0] upd;
      samp = m_d1;
      m_d1 = m_d0;
      m_d0 = raw_in;
      win.push_back(samp);
      if (win.size() > N) void'(win.pop_front());
      upd = '0;
      if (win.size() == N) begin
        for (int b = 0; b < W; b++) begin
          logic all_diff;
          all_diff = 1'b1;
          for (int i = 0; i < N; i++) if (win[i][b] == m_data[b]) all_diff = 1'b0;
          upd[b] = all_diff;
        end
      end
      m_data  = m_data ^ upd;
      m_pulse = |upd;
      if (|upd) m_flag = 1'b1;
      else if (clear_chg) m_flag = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cmp_data", data_out, m_data);
    check("cmp_pulse", 32'(chg_pulse), 32'(m_pulse));
    check("cmp_flag", 32'(chg_flag), 32'(m_flag));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle_zero();
    raw_in = '0;
    tick(N + 4);
    clear_chg = 1'b1;
    tick(1);
    clear_chg = 1'b0;
    tick(1);
  endtask

  initial begin
    raw_in = '1; clear_chg = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_data", data_out, 32'h0);
      check("rst_pulse", 32'(chg_pulse), 32'h0);
      check("rst_flag", 32'(chg_flag), 32'h0);
    end
    reset = 1'b0;
    tick(5);
    check("lat_e5", data_out, 32'h0);
    tick(1);
    check("lat_e6", data_out, 32'hFFFF_FFFF);
    check("lat_pulse", 32'(chg_pulse), 32'h1);
    check("lat_flag", 32'(chg_flag), 32'h1);
    tick(1);
    check("lat_pulse_once", 32'(chg_pulse), 32'h0);
    clear_chg = 1'b1; tick(1); clear_chg = 1'b0;
    check("clr_alone", 32'(chg_flag), 32'h0);

    settle_zero();
    raw_in = 32'h0000_00A5;
    tick(5);
    check("a5_e5", data_out, 32'h0);
    tick(1);
    check("a5_e6", data_out, 32'h0000_00A5);
    check("a5_pulse", 32'(chg_pulse), 32'h1);
    tick(1);
    check("a5_pulse_once", 32'(chg_pulse), 32'h0);

    settle_zero();
    raw_in = 32'h1; tick(3); raw_in = '0;
    tick(10);
    check("glitch_data", data_out, 32'h0);
    check("glitch_flag", 32'(chg_flag), 32'h0);

    for (int i = 0; i < 5; i++) begin
      raw_in = (i % 2 == 0) ? 32'h20 : 32'h0;
      tick(2);
    end
    tick(3);
    check("bounce_e5", data_out, 32'h0);
    tick(1);
    check("bounce_e6", data_out, 32'h20);
    check("bounce_pulse", 32'(chg_pulse), 32'h1);

    raw_in = '0;
    tick(5);
    clear_chg = 1'b1; tick(1); clear_chg = 1'b0;
    check("coinc_data", data_out, 32'h0);
    check("coinc_flag", 32'(chg_flag), 32'h1);
    clear_chg = 1'b1; tick(1); clear_chg = 1'b0;
    check("coinc_clr", 32'(chg_flag), 32'h0);

    raw_in = 32'h8;
    tick(4);
    check("mid_cnt_pre", 32'(dut.g_chan[3].u_bit.r_cnt), 32'h2);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_cnt", 32'(dut.g_chan[3].u_bit.r_cnt), 32'h0);
    check("mid_rst_data", data_out, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(5);
    check("mid_e5", data_out, 32'h0);
    tick(1);
    check("mid_e6", data_out, 32'h8);

    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (i == 1500) begin
        #1 reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      if ($urandom_range(3) == 0) raw_in = raw_in ^ ($urandom & $urandom & $urandom);
      clear_chg = ($urandom_range(7) == 0);
    end
    clear_chg = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
